// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: slave state enum and R/W bit encoding.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } slave_state_e;

  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for an asynchronous bus pin, with a history flop
// producing single-cycle rise/fall pulses aligned with the synchronized level.
module i2c_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Reset to the idle bus level so leaving reset on a quiet bus raises no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// multi-byte write and read with a byte-wide pulse interface to local logic.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus free or not addressed; only START is acted on
// ADDR     | shifting in the 7-bit address and R/W bit
// ADDR_ACK | address matched, ACK driven during the 9th clock
// WR_DATA  | shifting in a write byte
// WR_ACK   | ACK driven for a received write byte
// RD_DATA  | shifting out a read byte, MSB first
// RD_ACK   | SDA released; sampling master ACK/NACK
// IGNORE   | not for us or master NACKed; wait for START/STOP
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic       wr_valid_o,
  output logic [7:0] wr_data_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  slave_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   tx_q, tx_d;
  logic         byte_done_q, byte_done_d;
  logic         rw_q, rw_d;
  logic         sda_oe_q, sda_oe_d;
  logic         busy_q, busy_d;
  logic [7:0]   wr_data_q, wr_data_d;
  logic         wr_valid_q, wr_valid_d;
  logic         start_q, start_d;
  logic         stop_q, stop_d;
  logic         rd_req;
  logic         load_rd;

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // An SCL edge in the same cycle means the SDA change is a data bit.
  assign start_det = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_data_q   <= 8'h00;
      wr_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_fall && byte_done_q)
                    state_d = (shift_q[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall)
                    state_d = (rw_q == I2C_RW_READ) ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_fall && byte_done_q) state_d = WR_ACK;
        WR_ACK:   if (scl_fall) state_d = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt_q == 3'd0) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_lvl)              state_d = IGNORE;
          else if (scl_fall && byte_done_q)     state_d = RD_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    rd_req      = 1'b0;
    load_rd     = 1'b0;
    if (start_det) begin
      bit_cnt_d   = 3'd7;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      start_d     = 1'b1;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR, WR_DATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d = {shift_q[6:0], sda_lvl};
            if (bit_cnt_q == 3'd0) begin
              byte_done_d = 1'b1;
              if (state_q == WR_DATA) begin
                wr_data_d  = {shift_q[6:0], sda_lvl};
                wr_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == WR_DATA) begin
              sda_oe_d = 1'b1;
            end else begin
              rw_d = shift_q[0];
              if (shift_q[7:1] == SLAVE_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw_q == I2C_RW_READ) begin
            rd_req  = 1'b1;
            load_rd = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
          end
        end
        WR_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd7;
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            sda_oe_d  = ~tx_q[6];
          end else begin
            sda_oe_d    = 1'b0;
            byte_done_d = 1'b0;
          end
        end
        // byte_done doubles as "master ACKed" while waiting for the ACK-bit fall
        RD_ACK: begin
          if (scl_rise && !sda_lvl) begin
            byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            rd_req      = 1'b1;
            load_rd     = 1'b1;
          end
        end
        default: ;
      endcase
      if (load_rd) begin
        tx_d      = rd_data_i;
        sda_oe_d  = ~rd_data_i[7];
        bit_cnt_d = 3'd7;
      end
    end
  end

  assign sda_o      = 1'b0;
  assign sda_oe     = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_data_o  = wr_data_q;
  assign wr_valid_o = wr_valid_q;
  assign rd_req_o   = rd_req;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule
